// File: rtl/router_fsm_if.sv
// Handshake bundle between the router packet sequencer and its neighbours:
// packet-stream/FIFO status inputs and the Moore state-decode strobes.
interface router_fsm_if;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       fifo_full;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;

  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic       write_enb_reg;
  logic       busy;

  modport master (
    output pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full,
           fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, write_enb_reg, busy
  );

  modport slave (
    input  pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full,
           fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, write_enb_reg, busy
  );
endinterface

// File: rtl/router_fsm.sv
// Packet-sequencing Moore FSM of the 1x3 router; every output is a decode of
// the registered state, so strobes are glitch-free and input-independent.
module router_fsm (
  input  logic          clock,
  input  logic          resetn,
  router_fsm_if.slave   bus
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;

  // Port 3 is the invalid address; padding it with 0 keeps the lookups total.
  logic [3:0] empty_v, srst_v;
  logic       hdr_ok, port_srst;

  assign empty_v   = {1'b0, bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
  assign srst_v    = {1'b0, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
  assign hdr_ok    = bus.pkt_valid && (bus.data_in != 2'd3);
  assign port_srst = srst_v[addr_q];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    addr_d  = addr_q;
    state_d = state_q;
    if (state_q == DECODE_ADDRESS && bus.pkt_valid) addr_d = bus.data_in;

    // Timeout of the packet's own port aborts it from anywhere but idle.
    if (state_q != DECODE_ADDRESS && port_srst) begin
      state_d = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS:
          if (hdr_ok) state_d = empty_v[bus.data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        WAIT_TILL_EMPTY:
          if (empty_v[addr_q]) state_d = LOAD_FIRST_DATA;
        LOAD_FIRST_DATA:
          state_d = LOAD_DATA;
        LOAD_DATA:
          if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
          else if (!bus.pkt_valid) state_d = LOAD_PARITY;
        FIFO_FULL_STATE:
          if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (bus.parity_done)        state_d = DECODE_ADDRESS;
          else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
          else                        state_d = LOAD_DATA;
        LOAD_PARITY:
          state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        default:
          state_d = DECODE_ADDRESS;
      endcase
    end
  end

  assign bus.detect_add    = (state_q == DECODE_ADDRESS);
  assign bus.lfd_state     = (state_q == LOAD_FIRST_DATA);
  assign bus.ld_state      = (state_q == LOAD_DATA);
  assign bus.laf_state     = (state_q == LOAD_AFTER_FULL);
  assign bus.full_state    = (state_q == FIFO_FULL_STATE);
  assign bus.rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
  assign bus.write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                             (state_q == LOAD_AFTER_FULL);
  assign bus.busy          = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);

endmodule

// File: tb/tb_router_fsm.sv
// Directed and random stimulus for router_fsm, checked every cycle against a
// packet-level reference model of the sequencer.
module tb_router_fsm;
  logic clock = 1'b0;
  logic resetn;
  router_fsm_if bus ();

  router_fsm dut (.clock(clock), .resetn(resetn), .bus(bus));

  always #5 clock = ~clock;

  localparam int DA = 0, LFD = 1, LD = 2, LP = 3, FFS = 4, LAF = 5, WTE = 6, CPE = 7;

  int mst, maddr;
  int vectors = 0, miscompares = 0;

  // Expected {detect_add,lfd,ld,laf,full,rst_int,write_enb,busy} per phase.
  function automatic logic [7:0] expect_of(int s);
    case (s)
      DA:  return 8'b1000_0000;
      LFD: return 8'b0100_0001;
      LD:  return 8'b0010_0010;
      LP:  return 8'b0000_0011;
      FFS: return 8'b0000_1001;
      LAF: return 8'b0001_0011;
      WTE: return 8'b0000_0001;
      default: return 8'b0000_0101;
    endcase
  endfunction

  function automatic bit empty_of(int k);
    if (k == 0) return bus.fifo_empty_0;
    if (k == 1) return bus.fifo_empty_1;
    if (k == 2) return bus.fifo_empty_2;
    return 1'b0;
  endfunction

  function automatic bit srst_of(int k);
    if (k == 0) return bus.soft_reset_0;
    if (k == 1) return bus.soft_reset_1;
    if (k == 2) return bus.soft_reset_2;
    return 1'b0;
  endfunction

  task automatic drv(input bit pv, input bit [1:0] din, input bit pd, input bit lpv,
                     input bit ff, input bit e0, input bit e1, input bit e2,
                     input bit s0, input bit s1, input bit s2);
    bus.pkt_valid = pv;  bus.data_in = din; bus.parity_done = pd;
    bus.low_pkt_valid = lpv; bus.fifo_full = ff;
    bus.fifo_empty_0 = e0; bus.fifo_empty_1 = e1; bus.fifo_empty_2 = e2;
    bus.soft_reset_0 = s0; bus.soft_reset_1 = s1; bus.soft_reset_2 = s2;
  endtask

  // One clock: advance the model on the same inputs, then compare after the edge.
  task automatic step(input string tag);
    int ns, na;
    logic [7:0] obs, exp;
    @(posedge clock);
    ns = mst; na = maddr;
    if (!resetn) begin
      ns = DA; na = 0;
    end else begin
      if (mst == DA && bus.pkt_valid) na = int'(bus.data_in);
      if (mst != DA && srst_of(maddr)) ns = DA;
      else if (mst == DA) begin
        if (bus.pkt_valid && bus.data_in != 2'd3)
          ns = empty_of(int'(bus.data_in)) ? LFD : WTE;
      end
      else if (mst == WTE) ns = empty_of(maddr) ? LFD : WTE;
      else if (mst == LFD) ns = LD;
      else if (mst == LD)  ns = bus.fifo_full ? FFS : (!bus.pkt_valid ? LP : LD);
      else if (mst == FFS) ns = bus.fifo_full ? FFS : LAF;
      else if (mst == LAF) ns = bus.parity_done ? DA : (bus.low_pkt_valid ? LP : LD);
      else if (mst == LP)  ns = CPE;
      else                 ns = bus.fifo_full ? FFS : DA;
    end
    mst = ns; maddr = na;
    #1;
    obs = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
           bus.full_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};
    exp = expect_of(mst);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    mst = DA; maddr = 0;
    resetn = 1'b0;
    drv(0, 2'd0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    #2;
    step("reset");
    step("reset_hold");
    resetn = 1'b1;

    // Header to port 1 with its FIFO empty, then payload and parity.
    drv(1, 2'd1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    step("t1_lfd");
    step("t1_ld");
    for (int i = 0; i < 3; i++) step("t2_payload");
    bus.pkt_valid = 1'b0;
    step("t2_lp");
    step("t2_cpe");
    step("t2_da");

    // Port 0 still draining: wait, then load once it empties.
    drv(1, 2'd0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("t3_wte");
    bus.fifo_empty_0 = 1'b1;
    step("t3_lfd");
    step("t3_ld");

    // Full stall, flush, then parity via low_pkt_valid.
    bus.fifo_full = 1'b1;
    step("t4_ffs");
    step("t4_ffs_hold");
    bus.fifo_full = 1'b0;
    step("t4_laf");
    bus.low_pkt_valid = 1'b1;
    step("t4_lp");
    bus.low_pkt_valid = 1'b0;
    step("t4_cpe");
    step("t4_da");
    // Second stall ends with parity already captured.
    drv(1, 2'd0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    step("t4b_lfd");
    step("t4b_ld");
    bus.fifo_full = 1'b1;
    step("t4b_ffs");
    bus.fifo_full = 1'b0;
    bus.parity_done = 1'b1;
    step("t4b_laf");
    step("t4b_da");
    bus.parity_done = 1'b0;

    // Soft resets: only the packet's own port counts.
    drv(1, 2'd2, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    step("t5_lfd");
    step("t5_ld");
    bus.soft_reset_0 = 1'b1;
    step("t5_other_srst");
    bus.soft_reset_0 = 1'b0;
    bus.soft_reset_2 = 1'b1;
    step("t5_own_srst");
    bus.soft_reset_2 = 1'b0;

    // Invalid header dropped; hard reset mid-packet.
    drv(1, 2'd3, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    step("t6_bad_hdr");
    step("t6_bad_hdr2");
    bus.data_in = 2'd1;
    step("t6_lfd");
    step("t6_ld");
    resetn = 1'b0;
    step("t6_reset_mid");
    resetn = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      resetn = ($urandom_range(0, 39) != 0);
      drv($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
          $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
